// File: rtl/nes_button_events.sv
// NES pad button event capture: sync, debounce, sticky press/release
// flags with clear-on-read, and a pending-press level for the CPU.
module nes_button_events #(
    parameter int SAMPLE_DIV   = 50000,
    parameter int DEBOUNCE_CNT = 3,
    parameter int PAD_BITS     = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PAD_BITS-1:0] pad_data,
    input  logic                rd_en,
    input  logic [1:0]          rd_sel,
    output logic [PAD_BITS-1:0] rd_data,
    output logic                rd_valid,
    output logic                press_pending
);

    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(DEBOUNCE_CNT - 1);

    logic [TW-1:0]       tick_cnt;
    logic                tick;
    logic [PAD_BITS-1:0] sync1;
    logic [PAD_BITS-1:0] sync2;
    logic [PAD_BITS-1:0] deb;
    logic [PAD_BITS-1:0] deb_nxt;
    logic [CW-1:0]       stab     [PAD_BITS];
    logic [CW-1:0]       stab_nxt [PAD_BITS];
    logic [PAD_BITS-1:0] press;
    logic [PAD_BITS-1:0] release_f;
    logic [PAD_BITS-1:0] rise;
    logic [PAD_BITS-1:0] fall;
    logic [PAD_BITS-1:0] rd_val;
    logic [PAD_BITS-1:0] press_clr;
    logic [PAD_BITS-1:0] rel_clr;

    assign tick = (tick_cnt == TICK_LAST);

    // Free-running sample divider, wraps at SAMPLE_DIV-1
    always_ff @(posedge clk) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    // Two-flop synchronizer for the asynchronous pad bits
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pad_data;
            sync2 <= sync1;
        end
    end

    // Per-bit run length of disagreeing samples decides the next state
    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < PAD_BITS; i++) begin
            stab_nxt[i] = stab[i];
            if (tick) begin
                if (sync2[i] == deb[i]) begin
                    stab_nxt[i] = '0;
                end else if (stab[i] == STAB_LAST) begin
                    deb_nxt[i]  = ~deb[i];
                    stab_nxt[i] = '0;
                end else begin
                    stab_nxt[i] = stab[i] + CW'(1);
                end
            end
        end
    end

    // Debounced state and stability counters
    always_ff @(posedge clk) begin
        if (reset) begin
            deb <= '0;
            for (int i = 0; i < PAD_BITS; i++)
                stab[i] <= '0;
        end else begin
            deb <= deb_nxt;
            for (int i = 0; i < PAD_BITS; i++)
                stab[i] <= stab_nxt[i];
        end
    end

    assign rise = deb_nxt & ~deb;
    assign fall = ~deb_nxt & deb;

    // Read mux; a clearing read only drops the bits it returns
    always_comb begin
        rd_val    = '0;
        press_clr = '0;
        rel_clr   = '0;
        unique case (rd_sel)
            2'd0: rd_val = deb;
            2'd1: rd_val = press;
            2'd2: rd_val = release_f;
            default: rd_val = '0;
        endcase
        if (rd_en && rd_sel == 2'd1)
            press_clr = press;
        if (rd_en && rd_sel == 2'd2)
            rel_clr = release_f;
    end

    // Sticky flags; a new edge wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            press         <= '0;
            release_f     <= '0;
            press_pending <= 1'b0;
        end else begin
            press         <= (press & ~press_clr) | rise;
            release_f     <= (release_f & ~rel_clr) | fall;
            press_pending <= |press;
        end
    end

    // Registered read port with one-cycle valid pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_val;
        end
    end

endmodule
